// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter.
//   arb_state_e : ownership state (CORE_OWN / AUX_OWN)
//   DEF_AW/DEF_DW : default address/data widths
//   CNT_W : width of the wait and burst counters
package dmem_pkg;

  typedef enum logic {
    CORE_OWN = 1'b0,
    AUX_OWN  = 1'b1
  } arb_state_e;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
  localparam int CNT_W  = 4;

endpackage

// File: rtl/dmem_arb_fsm.sv
// dmem_arb_fsm: ownership state, anti-starvation and burst counters, grant decision.
// Ports:
//   clk, reset         : clock, async active-low reset
//   core_req           : core wants the port this cycle
//   aux_req, aux_lock  : aux request and burst-ownership request
//   core_grant         : core owns the port this cycle (combinational)
//   aux_grant          : aux owns the port this cycle (combinational)
module dmem_arb_fsm
  import dmem_pkg::*;
#(
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic core_req,
  input  logic aux_req,
  input  logic aux_lock,
  output logic core_grant,
  output logic aux_grant
);

  localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] BURST_END = CNT_W'(MAX_BURST - 1);
  localparam bit               LOCK_OK   = (MAX_BURST > 1);

  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_nxt;
  logic             blocked, blocked_nxt;  // one-cycle aux lockout after forced release
  logic             aux_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= CORE_OWN;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      blocked   <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      burst_cnt <= burst_nxt;
      blocked   <= blocked_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    burst_nxt   = burst_cnt;
    blocked_nxt = 1'b0;
    core_grant  = 1'b0;
    aux_grant   = 1'b0;
    aux_ok      = aux_req & ~blocked;
    // grants are gated by reset so the memory sees no access while held in reset
    if (reset) begin
      case (state)
        CORE_OWN: begin
          if (aux_ok && wait_cnt == WAIT_MAX) aux_grant  = 1'b1;
          else if (core_req)                  core_grant = 1'b1;
          else if (aux_ok)                    aux_grant  = 1'b1;
          // the entering beat is counted as part of the burst via BURST_END = MAX_BURST-1
          if (aux_grant && aux_lock && LOCK_OK) state_nxt = AUX_OWN;
          burst_nxt = '0;
        end
        AUX_OWN: begin
          if (aux_req)       aux_grant  = 1'b1;
          else if (core_req) core_grant = 1'b1;
          if (!aux_lock) begin
            state_nxt = CORE_OWN;
            burst_nxt = '0;
          end else if (aux_grant) begin
            if (burst_cnt + CNT_W'(1) == BURST_END) begin
              state_nxt   = CORE_OWN;
              burst_nxt   = '0;
              blocked_nxt = 1'b1;
            end else begin
              burst_nxt = burst_cnt + CNT_W'(1);
            end
          end
        end
        default: state_nxt = CORE_OWN;
      endcase
    end
    if (aux_grant || !aux_req)  wait_nxt = '0;
    else if (wait_cnt == WAIT_MAX) wait_nxt = wait_cnt;
    else                        wait_nxt = wait_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the MIPS MEM stage (core,
// default priority) and the AES loader/DMA (aux, anti-starvation + locked bursts).
// Ports:
//   clk, reset                      : clock, async active-low reset
//   core_read/write/addr/wdata      : core request; core_rdata/core_stall back
//   aux_req/we/lock/addr/wdata      : aux request; aux_ack/aux_rdata one cycle later
//   mem_addr/write/read/wdata/rdata : data memory port (combinational read)
// Optional: define DMEM_ARB_STATS_EN to add stat_core_stalls / stat_aux_beats.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_read,
  input  logic          core_write,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          aux_req,
  input  logic          aux_we,
  input  logic          aux_lock,
  input  logic [AW-1:0] aux_addr,
  input  logic [DW-1:0] aux_wdata,
  output logic          aux_ack,
  output logic [DW-1:0] aux_rdata,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]   stat_core_stalls,
  output logic [15:0]   stat_aux_beats,
`endif
  output logic [AW-1:0] mem_addr,
  output logic          mem_write,
  output logic          mem_read,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic core_req, core_grant, aux_grant;

  assign core_req = core_read | core_write;

  dmem_arb_fsm #(.MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .aux_req    (aux_req),
    .aux_lock   (aux_lock),
    .core_grant (core_grant),
    .aux_grant  (aux_grant)
  );

  assign core_stall = reset & core_req & ~core_grant;
  assign core_rdata = mem_rdata;

  // write wins over an (illegal) simultaneous core read
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    if (aux_grant) begin
      mem_addr  = aux_addr;
      mem_wdata = aux_wdata;
      mem_write = aux_we;
      mem_read  = ~aux_we;
    end else if (core_grant) begin
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_write = core_write;
      mem_read  = core_read & ~core_write;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aux_ack   <= 1'b0;
      aux_rdata <= '0;
    end else begin
      aux_ack <= aux_grant;
      if (aux_grant && !aux_we) aux_rdata <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_core_stalls <= '0;
      stat_aux_beats   <= '0;
    end else begin
      if (core_stall && stat_core_stalls != 16'hFFFF) stat_core_stalls <= stat_core_stalls + 16'd1;
      if (aux_grant && stat_aux_beats != 16'hFFFF)    stat_aux_beats   <= stat_aux_beats + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter with a small word memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_read, core_write;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_stall;
  logic        aux_req, aux_we, aux_lock;
  logic [31:0] aux_addr, aux_wdata, aux_rdata;
  logic        aux_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_core_stalls, stat_aux_beats;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4), .MAX_BURST(8)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .core_read  (core_read),
    .core_write (core_write),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .aux_req    (aux_req),
    .aux_we     (aux_we),
    .aux_lock   (aux_lock),
    .aux_addr   (aux_addr),
    .aux_wdata  (aux_wdata),
    .aux_ack    (aux_ack),
    .aux_rdata  (aux_rdata),
`ifdef DMEM_ARB_STATS_EN
    .stat_core_stalls (stat_core_stalls),
    .stat_aux_beats   (stat_aux_beats),
`endif
    .mem_addr   (mem_addr),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_read = 1'b0; core_write = 1'b0; core_addr = '0; core_wdata = '0;
    aux_req = 1'b0; aux_we = 1'b0; aux_lock = 1'b0; aux_addr = '0; aux_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  string pat;
  int    idx, na;
  bit    is_a;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h5A00_0000 | i;
    mem[4] = 32'hCAFE_F00D;
    mem[8] = 32'h1234_5678;

    // reset state, with requests asserted to confirm outputs stay quiet
    idle_inputs();
    reset = 1'b0;
    core_read = 1'b1; core_addr = 32'h10;
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h20;
    #2;
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_stall", core_stall, 1'b0);
    chk("rst_ack", aux_ack, 1'b0);
    chk("rst_rdata", aux_rdata, 32'h0);
    chk("rst_state", u_dut.u_fsm.state, 1'b0);
    do_reset();

    // core-only load
    core_read = 1'b1; core_addr = 32'h10;
    #1;
    chk("core_rdata", core_rdata, 32'hCAFE_F00D);
    chk("core_stall", core_stall, 1'b0);
    chk("core_mem_read", mem_read, 1'b1);
    tick();
    chk("core_no_ack", aux_ack, 1'b0);
    idle_inputs();

    // aux read with idle core
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h20;
    #1;
    chk("auxr_addr", mem_addr, 32'h20);
    chk("auxr_mem_read", mem_read, 1'b1);
    chk("auxr_ack_early", aux_ack, 1'b0);
    tick();
    chk("auxr_ack", aux_ack, 1'b1);
    chk("auxr_rdata", aux_rdata, 32'h1234_5678);
    aux_req = 1'b0;
    tick();
    chk("auxr_ack_once", aux_ack, 1'b0);
    chk("auxr_rdata_hold", aux_rdata, 32'h1234_5678);

    // starvation: aux wins in the 5th cycle of contention
    do_reset();
    core_read = 1'b1; core_addr = 32'h10;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h20;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("starve_stall", core_stall, (c == 4));
      chk("starve_addr", mem_addr, (c == 4) ? 32'h20 : 32'h10);
      tick();
    end
    chk("starve_ack", aux_ack, 1'b1);
    chk("starve_rdata", aux_rdata, 32'h1234_5678);
    aux_req = 1'b0;
    #1;
    chk("starve_core_back", core_stall, 1'b0);
    tick();
    chk("starve_ack_once", aux_ack, 1'b0);
`ifdef DMEM_ARB_STATS_EN
    chk("stat_stalls", stat_core_stalls, 16'd1);
    chk("stat_beats", stat_aux_beats, 16'd1);
`endif

    // locked burst of 10 aux writes against a continuous core store
    do_reset();
    core_write = 1'b1; core_addr = 32'h200; core_wdata = 32'hC0DE_0001;
    aux_we = 1'b1;
    pat = "CCCCAAAAAAAACCCCAAC";
    idx = 0;
    na  = 0;
    for (int c = 0; c < 19; c++) begin
      aux_req   = (idx < 10);
      aux_lock  = (idx < 10);
      aux_addr  = 32'h100 + 32'(4 * idx);
      aux_wdata = 32'hA000_0000 + 32'(idx);
      #1;
      is_a = (pat[c] == "A");
      chk($sformatf("burst_addr_c%0d", c), mem_addr, is_a ? 32'h100 + 32'(4 * na) : 32'h200);
      chk($sformatf("burst_stall_c%0d", c), core_stall, is_a);
      if (is_a) na++;
      tick();
      if (aux_ack) idx++;
    end
    idle_inputs();
    #1;
    for (int k = 0; k < 10; k++)
      chk($sformatf("burst_mem_%0d", k), mem[64 + k], 32'hA000_0000 + 32'(k));
    chk("burst_core_mem", mem[128], 32'hC0DE_0001);

    // reset asserted on the 3rd beat of a locked burst
    do_reset();
    aux_req = 1'b1; aux_lock = 1'b1; aux_we = 1'b1;
    for (int c = 0; c < 2; c++) begin
      aux_addr = 32'h300 + 32'(4 * c); aux_wdata = 32'hB000_0000 + 32'(c);
      tick();
    end
    aux_addr = 32'h308; aux_wdata = 32'hB000_0002;
    #1;
    reset = 1'b0;
    #1;
    chk("mid_mem_write", mem_write, 1'b0);
    chk("mid_ack", aux_ack, 1'b0);
    chk("mid_state", u_dut.u_fsm.state, 1'b0);
    chk("mid_wait", u_dut.u_fsm.wait_cnt, 4'd0);
    chk("mid_burst", u_dut.u_fsm.burst_cnt, 4'd0);
    tick();
    chk("mid_ack_after", aux_ack, 1'b0);
    chk("mid_beat2", mem[193], 32'hB000_0001);
    chk("mid_beat3_dropped", mem[194], 32'h5A00_00C2);
    idle_inputs();
    reset = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
